// File: rtl/adder_serial_n.sv
// Multi-cycle N-bit adder: s = a + b + ci, DIGIT bits per clock, LSB digit first.
// start/busy/done handshake; the result holds until the next operation completes.
module adder_serial_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NUM = WIDTH / DIGIT;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic               r_co;
    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_cnt;
    logic [DIGIT:0]     w_digit_sum;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_accept;
    logic               w_last;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("adder_serial_n: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;

    // Digit adder plus accept/last-digit qualifiers.
    always_comb begin
        w_digit_sum = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                    + (DIGIT+1)'(r_carry);
        w_accept    = (r_state != ST_RUN) && start;
        w_last      = (r_state == ST_RUN) && (r_cnt == CW'(NUM - 1));
    end

    // New digit enters the accumulator from the MSB end.
    generate
        if (WIDTH == DIGIT) begin : g_acc_single
            assign w_acc_next = w_digit_sum[DIGIT-1:0];
        end else begin : g_acc_shift
            assign w_acc_next = {w_digit_sum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
                else       w_state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (w_last) w_state_next = ST_DONE;
                else        w_state_next = ST_RUN;
            end
            ST_DONE: begin
                if (start) w_state_next = ST_RUN;
                else       w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Operand capture, digit-serial datapath and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_acc   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_s     <= {WIDTH{1'b0}};
            r_co    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_acc   <= {WIDTH{1'b0}};
            r_carry <= ci;
            r_cnt   <= {CW{1'b0}};
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_acc   <= w_acc_next;
            r_carry <= w_digit_sum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_s  <= w_acc_next;
                r_co <= w_digit_sum[DIGIT];
            end else begin
                r_s  <= r_s;
                r_co <= r_co;
            end
        end else begin
            r_a_sh  <= r_a_sh;
            r_b_sh  <= r_b_sh;
            r_acc   <= r_acc;
            r_carry <= r_carry;
            r_cnt   <= r_cnt;
        end
    end

endmodule

// File: tb/tb_adder_serial_n.sv
// Bench for adder_serial_n: five configurations share one stimulus stream, each
// compared every cycle against a transaction-level model, plus directed literals.
module tb_adder_serial_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;

    int total  = 0;
    int passed = 0;

    logic [4:0] busy_v;
    logic [4:0] done_v;
    logic [7:0] s_v [5];
    logic       co_v [5];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a = av; b = bv; ci = cv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int g, output int n);
        n = 0;
        while (!done_v[g] && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_v != 5'd0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, {27'd0, busy_v}, 32'd0);
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int W = (g < 3) ? 8 : 4;
        localparam int D = (g == 0 || g == 3) ? 1 : ((g == 1 || g == 4) ? 2 : 4);

        logic         busy, done, co;
        logic [W-1:0] s;

        adder_serial_n #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .a(a[W-1:0]), .b(b[W-1:0]), .ci(ci),
            .busy(busy), .done(done), .s(s), .co(co)
        );

        assign busy_v[g] = busy;
        assign done_v[g] = done;
        assign s_v[g]    = 8'(s);
        assign co_v[g]   = co;

        // Reference: an accepted request completes W/D edges later with a+b+ci.
        logic         m_busy, m_done, m_co;
        logic [W-1:0] m_s;
        logic [W:0]   m_pend;
        int           m_rem;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_busy <= 1'b0; m_done <= 1'b0; m_co <= 1'b0;
                m_s <= '0; m_pend <= '0; m_rem <= 0;
            end else begin
                m_done <= 1'b0;
                if (m_busy) begin
                    if (m_rem == 1) begin
                        {m_co, m_s} <= m_pend;
                        m_done <= 1'b1;
                        m_busy <= 1'b0;
                    end else begin
                        m_rem <= m_rem - 1;
                    end
                end else if (start) begin
                    m_pend <= (W+1)'(a[W-1:0]) + (W+1)'(b[W-1:0]) + (W+1)'(ci);
                    m_rem  <= W / D;
                    m_busy <= 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            total++;
            if ({busy, done, co, s} === {m_busy, m_done, m_co, m_s}) passed++;
            else $display("FAIL cycle_W%0d_D%0d t=%0t: busy/done/co/s got %b/%b/%b/%h expected %b/%b/%b/%h",
                          W, D, $time, busy, done, co, s, m_busy, m_done, m_co, m_s);
        end
    end

    initial begin
        int n;
        logic seen;
        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
        tick(); tick();
        chk("reset_busy", {27'd0, busy_v}, 32'd0);
        chk("reset_s0", {24'd0, s_v[0]}, 32'd0);
        reset = 1'b0;
        tick();

        // All-ones + 1 wraps to zero with carry out, 8 cycles at DIGIT=1.
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(0, n);
        chk("t1_latency", n, 32'd8);
        chk("t1_s", {24'd0, s_v[0]}, 32'h00);
        chk("t1_co", {31'd0, co_v[0]}, 32'd1);
        wait_idle("t1_idle");

        // DIGIT=4: two cycles.
        start_op(8'h3C, 8'h45, 1'b1);
        wait_done(2, n);
        chk("t2_latency", n, 32'd2);
        chk("t2_s", {24'd0, s_v[2]}, 32'h82);
        chk("t2_co", {31'd0, co_v[2]}, 32'd0);
        wait_idle("t2_idle");

        // start pulsed mid-run must not disturb the DIGIT=1 operation.
        start_op(8'h00, 8'h01, 1'b0);
        tick(); tick(); tick();
        a = 8'hFF; b = 8'hFF; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, n);
        chk("t3_latency", n, 32'd4);
        chk("t3_s", {24'd0, s_v[0]}, 32'h01);
        chk("t3_co", {31'd0, co_v[0]}, 32'd0);
        wait_idle("t3_idle");

        // Asynchronous reset in the second run cycle of DIGIT=2.
        start_op(8'hAA, 8'h55, 1'b1);
        tick();
        chk("t4_busy_pre", {31'd0, busy_v[1]}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_busy", {31'd0, busy_v[1]}, 32'd0);
        chk("t4_done", {31'd0, done_v[1]}, 32'd0);
        chk("t4_s", {24'd0, s_v[1]}, 32'd0);
        chk("t4_co", {31'd0, co_v[1]}, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | done_v[1];
        end
        chk("t4_no_done", {31'd0, seen}, 32'd0);

        // start held through DONE: second operation follows with no bubble.
        a = 8'h01; b = 8'h02; ci = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        a = 8'h80; b = 8'h80;
        tick();
        chk("t5_done1", {31'd0, done_v[0]}, 32'd1);
        chk("t5_s1", {24'd0, s_v[0]}, 32'h03);
        tick();
        chk("t5_busy2", {31'd0, busy_v[0]}, 32'd1);
        chk("t5_hold", {24'd0, s_v[0]}, 32'h03);
        start = 1'b0;
        wait_done(0, n);
        chk("t5_latency", n, 32'd8);
        chk("t5_s2", {24'd0, s_v[0]}, 32'h00);
        chk("t5_co2", {31'd0, co_v[0]}, 32'd1);
        wait_idle("t5_idle");

        // Random traffic, including stray resets and operand churn.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            ci    = 1'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0;
        wait_idle("rand_idle");

        // Exhaustive 4-bit operands for DIGIT=1 and DIGIT=2.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    start_op(8'(ai), 8'(bi), 1'(c));
                    wait_idle("x_idle");
                    chk("x_w4d1", {27'd0, co_v[3], s_v[3][3:0]}, 32'(ai + bi + c));
                    chk("x_w4d2", {27'd0, co_v[4], s_v[4][3:0]}, 32'(ai + bi + c));
                end
            end
        end

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
